mcpu_dbg_bus_master: RTL and testbench

- Debug bus initiator that drives the SoC MMIO word bus (addr[30:2], write data, per-byte write enables, combinational read data) from the requester side.
- Commands arrive as a byte stream from a UART receiver. Responses leave as a byte stream to a UART transmitter.
- Lets a host poke and peek LED/switch, UART and any other MMIO register without CPU involvement.
- Sits between the UART byte interfaces and an MMIO responder, in place of or muxed with the core's data port.

---
 rtl/mcpu_dbg_bus_master_if.sv | 24 ++
 rtl/mcpu_dbg_bus_master.sv | 175 +++++++++++++++++
 tb/tb_mcpu_dbg_bus_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_dbg_bus_master_if.sv
// Debug bus master signal bundle: UART byte streams, MMIO word bus and busy flag.
// master = the debug bus master itself, slave = UART/MMIO side.
interface mcpu_dbg_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [28:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wren;
  logic [31:0] bus_rdata;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_rdata,
    output tx_data, tx_valid, bus_addr, bus_wdata, bus_wren, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_rdata,
    input  tx_data, tx_valid, bus_addr, bus_wdata, bus_wren, busy
  );
endinterface

// File: rtl/mcpu_dbg_bus_master.sv
// UART-byte-driven MMIO initiator: parses 'W'/'R' commands, performs the bus access,
// and streams ACK / NAK / read data back out.
module mcpu_dbg_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  NAK_BYTE    = 8'h3F
) (
  input  logic                         clkrst_core_clk,
  input  logic                         clkrst_core_rst,
  mcpu_dbg_bus_master_if.master        dbg
);

  localparam int unsigned TO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_BE, S_GET_DATA, S_WRITE, S_READ_SETUP, S_READ_CAP, S_SEND
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_wr;
  logic [1:0]        r_byte_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [28:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [23:0]       r_resp;
  logic [1:0]        r_left;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic [3:0]        r_bus_wren;
  logic              r_busy;

  logic              w_in_get;
  logic              w_timeout;
  logic              w_op_ok;
  logic              w_tx_valid_nxt;
  logic [3:0]        w_bus_wren_nxt;
  logic              w_busy_nxt;

  assign w_in_get  = (r_state == S_GET_ADDR) || (r_state == S_GET_BE) || (r_state == S_GET_DATA);
  assign w_timeout = w_in_get && !dbg.rx_valid && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_op_ok   = (dbg.rx_data == OP_WRITE) || (dbg.rx_data == OP_READ);

  // State register
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (dbg.rx_valid) w_state_nxt = w_op_ok ? S_GET_ADDR : S_SEND;
      end
      S_GET_ADDR: begin
        if (dbg.rx_valid && (r_byte_cnt == 2'd3)) w_state_nxt = r_is_wr ? S_GET_BE : S_READ_SETUP;
        else if (w_timeout)                       w_state_nxt = S_IDLE;
      end
      S_GET_BE: begin
        if (dbg.rx_valid)   w_state_nxt = S_GET_DATA;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_GET_DATA: begin
        if (dbg.rx_valid && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
        else if (w_timeout)                       w_state_nxt = S_IDLE;
      end
      S_WRITE:      w_state_nxt = S_SEND;
      S_READ_SETUP: w_state_nxt = S_READ_CAP;
      S_READ_CAP:   w_state_nxt = S_SEND;
      S_SEND: begin
        if (dbg.tx_ready && (r_left == 2'd0)) w_state_nxt = S_IDLE;
      end
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode, one cycle ahead so the outputs leave straight from flops
  always_comb begin
    w_busy_nxt     = 1'b0;
    w_tx_valid_nxt = 1'b0;
    w_bus_wren_nxt = 4'h0;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_tx_valid_nxt = (w_state_nxt == S_SEND);
    if (w_state_nxt == S_WRITE) w_bus_wren_nxt = r_be;
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_is_wr    <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_to_cnt   <= '0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_resp     <= '0;
      r_left     <= 2'd0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_bus_wren <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_valid <= w_tx_valid_nxt;
      r_bus_wren <= w_bus_wren_nxt;
      r_busy     <= w_busy_nxt;

      // Inter-byte gap counter, only live while a command is being collected
      if (w_in_get && !dbg.rx_valid && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                         r_to_cnt <= '0;

      if (dbg.rx_valid) begin
        case (r_state)
          S_IDLE: begin
            r_is_wr    <= (dbg.rx_data == OP_WRITE);
            r_byte_cnt <= 2'd0;
          end
          S_GET_ADDR: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Byte address A[30:2] packed straight into the word address
            case (r_byte_cnt)
              2'd0:    r_addr[5:0]   <= dbg.rx_data[7:2];
              2'd1:    r_addr[13:6]  <= dbg.rx_data;
              2'd2:    r_addr[21:14] <= dbg.rx_data;
              default: r_addr[28:22] <= dbg.rx_data[6:0];
            endcase
          end
          S_GET_BE: r_be <= dbg.rx_data[3:0];
          S_GET_DATA: begin
            r_byte_cnt                        <= r_byte_cnt + 2'd1;
            r_wdata[{r_byte_cnt, 3'b000} +: 8] <= dbg.rx_data;
          end
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (dbg.rx_valid && !w_op_ok) begin
            r_tx_data <= NAK_BYTE;
            r_left    <= 2'd0;
          end
        end
        S_WRITE: begin
          r_tx_data <= ACK_BYTE;
          r_left    <= 2'd0;
        end
        S_READ_CAP: begin
          r_tx_data <= dbg.bus_rdata[7:0];
          r_resp    <= dbg.bus_rdata[31:8];
          r_left    <= 2'd3;
        end
        S_SEND: begin
          if (dbg.tx_ready && (r_left != 2'd0)) begin
            r_tx_data <= r_resp[7:0];
            r_resp    <= {8'h00, r_resp[23:8]};
            r_left    <= r_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg.tx_data   = r_tx_data;
  assign dbg.tx_valid  = r_tx_valid;
  assign dbg.bus_addr  = r_addr;
  assign dbg.bus_wdata = r_wdata;
  assign dbg.bus_wren  = r_bus_wren;
  assign dbg.busy      = r_busy;

endmodule

// File: tb/tb_mcpu_dbg_bus_master.sv
// Bench for mcpu_dbg_bus_master: command-level model predicting bus strobes and tx bytes,
// with a per-cycle monitor comparing the DUT against it.
module tb_mcpu_dbg_bus_master;
  localparam int unsigned T = 16;
  localparam logic [31:0] K = 32'h01000193;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = 32'd0;
  logic [31:0] last_c = 32'd0;
  logic [31:0] rd_base [16];
  logic        rd_tick = 1'b0;
  int          rdy_mode = 1;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [28:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wren;
    logic [31:0] cyc;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  mcpu_dbg_bus_master_if dif();

  mcpu_dbg_bus_master #(.TIMEOUT_CYC(T), .ACK_BYTE(8'h4B), .NAK_BYTE(8'h3F)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .dbg             (dif.master)
  );

  // Responder: data depends on word address and current cycle so capture timing is visible
  assign dif.bus_rdata = rd_base[dif.bus_addr[3:0]] ^ (rd_tick ? cyc * K : 32'h0);

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // tx_ready driver: 0 random, 1 always, 2 five stall cycles per byte, 3 never
  initial begin
    int stall;
    stall = 0;
    dif.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: dif.tx_ready = 1'($urandom_range(0, 1));
        1: dif.tx_ready = 1'b1;
        2: begin
          if (dif.tx_valid) begin
            if (stall == 5) begin dif.tx_ready = 1'b1; stall = 0; end
            else            begin dif.tx_ready = 1'b0; stall++;   end
          end else begin
            dif.tx_ready = 1'b0;
            stall = 0;
          end
        end
        default: dif.tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every strobe and every accepted byte must match the model's queues
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", 64'(dif.tx_valid), 64'd1);
        chk("tx_hold_data", 64'(dif.tx_data), 64'(prev_data));
      end
      if (dif.tx_valid && dif.tx_ready) begin
        chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) begin
          chk("tx_byte", 64'(dif.tx_data), 64'(exp_tx[0]));
          void'(exp_tx.pop_front());
        end
      end
      if (dif.bus_wren != 4'h0) begin
        chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          chk("wr_addr", 64'(dif.bus_addr), 64'(exp_wr[0].addr));
          chk("wr_data", 64'(dif.bus_wdata), 64'(exp_wr[0].wdata));
          chk("wr_en", 64'(dif.bus_wren), 64'(exp_wr[0].wren));
          chk("wr_cycle", 64'(cyc), 64'(exp_wr[0].cyc));
          void'(exp_wr.pop_front());
        end
      end
      prev_stall <= dif.tx_valid && !dif.tx_ready;
      prev_data  <= dif.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    dif.rx_data  = b;
    dif.rx_valid = 1'b1;
    last_c       = cyc;
    @(posedge clk); #1;
    dif.rx_valid = 1'b0;
  endtask

  function automatic int rgap(input int maxg);
    return ($urandom_range(0, 5) == 0) ? maxg : int'($urandom_range(0, 2));
  endfunction

  // Wait for the command to drain; sprinkles junk rx bytes during SEND, which must be dropped
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((dif.busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
      dif.rx_valid = 1'b0;
      if (dif.tx_valid && $urandom_range(0, 3) == 0) begin
        dif.rx_data  = 8'($urandom);
        dif.rx_valid = 1'b1;
      end
    end
    dif.rx_valid = 1'b0;
    chk("drained", {61'd0, dif.busy, 1'(exp_tx.size() != 0), 1'(exp_wr.size() != 0)}, 64'd0);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [7:0] be,
                         input logic [31:0] d, input int maxg);
    logic [31:0] v;
    send_byte(op, 0);
    if (op == 8'h57 || op == 8'h52) begin
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], rgap(maxg));
      if (op == 8'h57) begin
        send_byte(be, rgap(maxg));
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], rgap(maxg));
        if (be[3:0] != 4'h0)
          exp_wr.push_back('{addr: a[30:2], wdata: d, wren: be[3:0], cyc: last_c + 32'd1});
        exp_tx.push_back(8'h4B);
      end else begin
        v = rd_base[a[5:2]] ^ (rd_tick ? (last_c + 32'd2) * K : 32'h0);
        for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
      end
    end else begin
      exp_tx.push_back(8'h3F);
    end
    wait_done(4000);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_data"}, 64'(dif.tx_data), 64'd0);
    chk({tag, "_tx_valid"}, 64'(dif.tx_valid), 64'd0);
    chk({tag, "_bus_addr"}, 64'(dif.bus_addr), 64'd0);
    chk({tag, "_bus_wdata"}, 64'(dif.bus_wdata), 64'd0);
    chk({tag, "_bus_wren"}, 64'(dif.bus_wren), 64'd0);
    chk({tag, "_busy"}, 64'(dif.busy), 64'd0);
  endtask

  logic [7:0] wcmd [10];
  logic [7:0] rcmd [5];

  initial begin
    int n;
    logic [7:0] op;
    int r;
    wcmd = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rcmd = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 16; i++) rd_base[i] = $urandom;
    rd_base[1] = 32'h12345678;
    dif.rx_data  = 8'h00;
    dif.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed write, literal expectations
    for (int i = 0; i < 10; i++) send_byte(wcmd[i], 0);
    exp_wr.push_back('{addr: 29'h400, wdata: 32'hDEADBEEF, wren: 4'b0011, cyc: last_c + 32'd1});
    exp_tx.push_back(8'h4B);
    wait_done(200);

    // Directed read, bit 31 of the address ignored
    for (int i = 0; i < 5; i++) send_byte(rcmd[i], 0);
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    wait_done(200);
    chk("rd_addr", 64'(dif.bus_addr), 64'd1);

    // Same read under heavy backpressure
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) send_byte(rcmd[i], 0);
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    wait_done(300);
    rdy_mode = 1;

    // Unknown opcode, then a normal read
    send_byte(8'h00, 0);
    exp_tx.push_back(8'h3F);
    wait_done(100);
    run_cmd(8'h52, 32'h0000_0004, 8'h00, 32'h0, 0);

    // Timeout: busy holds for exactly T idle cycles, then drops with no bus access or reply
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (T - 1) begin @(posedge clk); #1; end
    chk("to_busy_before", 64'(dif.busy), 64'd1);
    @(posedge clk); #1;
    chk("to_busy_after", 64'(dif.busy), 64'd0);
    repeat (5) begin @(posedge clk); #1; end
    chk("to_no_wren", 64'(dif.bus_wren), 64'd0);
    chk("to_no_tx", 64'(dif.tx_valid), 64'd0);
    for (int i = 0; i < 10; i++) send_byte(wcmd[i], 0);
    exp_wr.push_back('{addr: 29'h400, wdata: 32'hDEADBEEF, wren: 4'b0011, cyc: last_c + 32'd1});
    exp_tx.push_back(8'h4B);
    wait_done(200);

    // BE = 0 (upper nibble ignored): no visible strobe, still ACKed
    run_cmd(8'h57, 32'h0000_0020, 8'hF0, 32'h55AA55AA, 0);

    // Reset during GET_DATA
    rd_tick = 1'b1;
    send_byte(8'h57, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h44, 0);
    send_byte(8'h0F, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_data");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_hold_wren", 64'(dif.bus_wren), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmd(8'h52, 32'h0000_0018, 8'h00, 32'h0, 3);

    // Reset mid-SEND: pending byte abandoned
    rdy_mode = 3;
    send_byte(8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h08, 0);
    n = 0;
    while (!dif.tx_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("send_reached", 64'(dif.tx_valid), 64'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_reset_vals("rst_send");
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    chk("rst_send_tx_valid", 64'(dif.tx_valid), 64'd0);
    run_cmd(8'h57, 32'h0000_0100, 8'h0C, 32'hCAFEF00D, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
      end else if (r <= 5) op = 8'h57;
      else                 op = 8'h52;
      run_cmd(op, $urandom, 8'($urandom), $urandom, T - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
